// File: rtl/dc_filter_pkg.sv
// dc_filter_pkg: shared widths, sample/accumulator types and a sign-extension
// helper for the time-multiplexed DC-blocking filter.
package dc_filter_pkg;

   localparam int N_DECIMALS = 23;
   localparam int SAMPLE_W   = 9;
   localparam int OUT_W      = N_DECIMALS + SAMPLE_W;

   typedef logic signed [SAMPLE_W-1:0] sample_t;
   typedef logic signed [OUT_W-1:0]    acc_t;

   // Widen a 9-bit signed sample to the 32-bit accumulator format.
   function automatic acc_t sext_sample(input sample_t x);
      return {{(OUT_W-SAMPLE_W){x[SAMPLE_W-1]}}, x};
   endfunction

endpackage

// File: rtl/dc_filter_scheduler_rr_arbiter.sv
// rr_arbiter: round-robin requester selection. The search starts one past the
// last served requester; `last` starts at N-1 so requester 0 wins first.
module rr_arbiter #(
   parameter int N = 4,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic          CLK_3M,
   input  logic          reset,
   input  logic [N-1:0]  req_i,
   input  logic          en_i,
   input  logic          advance_i,
   output logic [N-1:0]  grant_o,
   output logic [IW-1:0] index_o
);

   logic [IW-1:0] last_q;
   logic [IW-1:0] last_d;
   logic          found_s;

   // Pick the first requester at or after last+1, wrapping modulo N.
   always_comb begin
      grant_o = '0;
      index_o = '0;
      found_s = 1'b0;
      for (int off = 1; off <= N; off++) begin
         int pos;
         pos = (int'(last_q) + off) % N;
         if (en_i && !found_s && req_i[pos]) begin
            found_s      = 1'b1;
            grant_o[pos] = 1'b1;
            index_o      = pos[IW-1:0];
         end else begin
         end
      end
   end

   // Remember the served requester so it drops to lowest priority.
   always_comb begin
      if (advance_i) begin
         last_d = index_o;
      end else begin
         last_d = last_q;
      end
   end

   // Pointer register with synchronous active-low reset.
   always_ff @(posedge CLK_3M) begin
      if (!reset) begin
         last_q <= IW'(N - 1);
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/dc_filter_scheduler.sv
// dc_filter_scheduler: one shared DC-blocking filter serving N_CH channels.
// Round-robin grants, per-channel (prev input, prev output) state, one result
// per cycle into a single registered output slot with valid/ready.
// Optional feature macro: DC_FAST_SETTLE_EN (fast leak for first samples).
module dc_filter_scheduler
   import dc_filter_pkg::*;
#(
   parameter int N_CH           = 4,
   parameter int SHIFT          = 16,
   parameter int FAST_SHIFT     = 8,
   parameter int SETTLE_SAMPLES = 256,
   localparam int IW            = $clog2(N_CH)
) (
   input  logic                     CLK_3M,
   input  logic                     reset,
   input  logic                     enable,
   input  logic [N_CH-1:0]          ch_valid,
   input  logic [SAMPLE_W*N_CH-1:0] ch_data,
   input  logic [N_CH-1:0]          ch_clear,
   output logic [N_CH-1:0]          ch_ready,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [IW-1:0]            out_ch,
   output logic [OUT_W-1:0]         out_data
);

   localparam logic [4:0] SH_SLOW = 5'(SHIFT);

   sample_t         b_q [N_CH];
   acc_t            e_q [N_CH];
   logic            out_valid_q;
   acc_t            out_data_q;
   logic [IW-1:0]   out_ch_q;

   sample_t         samp_s [N_CH];
   logic [N_CH-1:0] req_s;
   logic [N_CH-1:0] grant_s;
   logic [IW-1:0]   gnt_idx_s;
   logic            arb_en_s;
   logic            xfer_s;
   sample_t         x_s;
   acc_t            e_sel_s;
   acc_t            c_s;
   acc_t            es_s;
   acc_t            g_s;
   acc_t            d_s;
   logic            r_s;
   logic [4:0]      sh_s;

   // Unpack the flat channel bus into per-channel samples.
   always_comb begin
      for (int i = 0; i < N_CH; i++) begin
         samp_s[i] = ch_data[SAMPLE_W*i +: SAMPLE_W];
      end
   end

   // Clear beats grant; grants only with a free output slot.
   always_comb begin
      req_s    = ch_valid & ~ch_clear;
      arb_en_s = reset & enable & (~out_valid_q | out_ready);
      xfer_s   = |(grant_s & ch_valid);
   end

   rr_arbiter #(.N(N_CH)) u_arb (
      .CLK_3M    (CLK_3M),
      .reset     (reset),
      .req_i     (req_s),
      .en_i      (arb_en_s),
      .advance_i (xfer_s),
      .grant_o   (grant_s),
      .index_o   (gnt_idx_s)
   );

   assign ch_ready = grant_s;

`ifdef DC_FAST_SETTLE_EN
   localparam int         CW      = $clog2(SETTLE_SAMPLES + 1);
   localparam logic [4:0] SH_FAST = 5'(FAST_SHIFT);
   localparam logic [CW-1:0] CNT_MAX = CW'(SETTLE_SAMPLES);

   logic [CW-1:0] cnt_q [N_CH];

   // Fast leak while the granted channel is still settling.
   always_comb begin
      if (cnt_q[gnt_idx_s] < CNT_MAX) begin
         sh_s = SH_FAST;
      end else begin
         sh_s = SH_SLOW;
      end
   end

   // Per-channel transferred-sample counters, saturating at SETTLE_SAMPLES.
   always_ff @(posedge CLK_3M) begin
      if (!reset) begin
         for (int i = 0; i < N_CH; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            if (ch_clear[i]) begin
               cnt_q[i] <= '0;
            end else if (xfer_s && (gnt_idx_s == IW'(i)) && (cnt_q[i] < CNT_MAX)) begin
               cnt_q[i] <= cnt_q[i] + CW'(1);
            end else begin
               cnt_q[i] <= cnt_q[i];
            end
         end
      end
   end
`else
   // Steady-state leak only.
   always_comb begin
      sh_s = SH_SLOW;
   end
`endif

   // Leaky differentiator: d = ((x - b) << 23) + e - round(e >> s).
   always_comb begin
      x_s     = samp_s[gnt_idx_s];
      e_sel_s = e_q[gnt_idx_s];
      c_s     = sext_sample(x_s) - sext_sample(b_q[gnt_idx_s]);
      es_s    = e_sel_s >>> sh_s;
      r_s     = e_sel_s[sh_s - 5'd1];
      g_s     = e_sel_s - (es_s + acc_t'({31'b0, r_s}));
      d_s     = (c_s <<< N_DECIMALS) + g_s;
   end

   // Per-channel filter state: clear wins, else update on transfer.
   always_ff @(posedge CLK_3M) begin
      if (!reset) begin
         for (int i = 0; i < N_CH; i++) begin
            b_q[i] <= '0;
            e_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            if (ch_clear[i]) begin
               b_q[i] <= '0;
               e_q[i] <= '0;
            end else if (xfer_s && (gnt_idx_s == IW'(i))) begin
               b_q[i] <= x_s;
               e_q[i] <= d_s;
            end else begin
               b_q[i] <= b_q[i];
               e_q[i] <= e_q[i];
            end
         end
      end
   end

   // Single-entry output slot; a new transfer refills it in the same cycle.
   always_ff @(posedge CLK_3M) begin
      if (!reset) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_ch_q    <= '0;
      end else if (xfer_s) begin
         out_valid_q <= 1'b1;
         out_data_q  <= d_s;
         out_ch_q    <= gnt_idx_s;
      end else if (out_ready) begin
         out_valid_q <= 1'b0;
         out_data_q  <= out_data_q;
         out_ch_q    <= out_ch_q;
      end else begin
         out_valid_q <= out_valid_q;
         out_data_q  <= out_data_q;
         out_ch_q    <= out_ch_q;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_dc_filter_scheduler.sv
// Self-checking bench for dc_filter_scheduler: arithmetic reference model,
// directed scenarios with hand-computed literals, then randomized traffic.
module tb_dc_filter_scheduler;

   localparam int N      = 4;
   localparam int SHIFT  = 16;
   localparam int FAST   = 8;
   localparam int SETTLE = 256;

   logic          CLK_3M;
   logic          reset;
   logic          enable;
   logic [N-1:0]  ch_valid;
   logic [9*N-1:0] ch_data;
   logic [N-1:0]  ch_clear;
   logic [N-1:0]  ch_ready;
   logic          out_valid;
   logic          out_ready;
   logic [1:0]    out_ch;
   logic [31:0]   out_data;

   dc_filter_scheduler #(
      .N_CH(N), .SHIFT(SHIFT), .FAST_SHIFT(FAST), .SETTLE_SAMPLES(SETTLE)
   ) dut (
      .CLK_3M(CLK_3M), .reset(reset), .enable(enable),
      .ch_valid(ch_valid), .ch_data(ch_data), .ch_clear(ch_clear),
      .ch_ready(ch_ready), .out_valid(out_valid), .out_ready(out_ready),
      .out_ch(out_ch), .out_data(out_data)
   );

   initial CLK_3M = 1'b0;
   always #5 CLK_3M = ~CLK_3M;

   // reference model state
   int mb [N];
   int me [N];
   int mcnt [N];
   int mlast;
   int mv;
   int mdata;
   int mch;
   int samp [N];

   int n_cmp = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < N; i++) begin
         mb[i] = 0; me[i] = 0; mcnt[i] = 0;
      end
      mlast = N - 1; mv = 0; mdata = 0; mch = 0;
   endfunction

   function automatic int filt(input int x, input int b, input int e, input int s);
      int rnd;
      rnd = (e >>> (s - 1)) & 1;
      return ((x - b) * 8388608) + e - ((e >>> s) + rnd);
   endfunction

   // One clock: inputs already set; check grant, advance model, check outputs.
   task automatic cycle();
      logic [N-1:0] exp_rdy;
      int k, s, d;
      for (int i = 0; i < N; i++) ch_data[9*i +: 9] = samp[i][8:0];
      #1;
      k = -1;
      exp_rdy = '0;
      if (reset && enable && (mv == 0 || out_ready)) begin
         for (int off = 1; off <= N; off++) begin
            int p;
            p = (mlast + off) % N;
            if (k < 0 && ch_valid[p] && !ch_clear[p]) k = p;
         end
      end
      if (k >= 0) exp_rdy[k] = 1'b1;
      chk("ch_ready", {28'b0, ch_ready}, {28'b0, exp_rdy});
      if (!reset) begin
         model_reset();
      end else begin
         d = 0;
         if (k >= 0) begin
            s = SHIFT;
`ifdef DC_FAST_SETTLE_EN
            if (mcnt[k] < SETTLE) s = FAST;
`endif
            d = filt(samp[k], mb[k], me[k], s);
         end
         for (int i = 0; i < N; i++) begin
            if (ch_clear[i]) begin
               mb[i] = 0; me[i] = 0; mcnt[i] = 0;
            end
         end
         if (k >= 0) begin
            mb[k] = samp[k]; me[k] = d;
            if (mcnt[k] < SETTLE) mcnt[k]++;
            mdata = d; mch = k; mv = 1; mlast = k;
         end else if (out_ready) begin
            mv = 0;
         end
      end
      @(posedge CLK_3M);
      #1;
      chk("out_valid", {31'b0, out_valid}, mv[31:0]);
      chk("out_data", out_data, mdata[31:0]);
      chk("out_ch", {30'b0, out_ch}, mch[31:0]);
   endtask

   task automatic idle_inputs();
      ch_valid = '0; ch_clear = '0; enable = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < N; i++) samp[i] = 0;
   endtask

   initial begin
      model_reset();
      idle_inputs();
      reset = 1'b0;
      ch_data = '0;
      // reset state
      cycle();
      cycle();
      chk("rst_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_data", out_data, 32'd0);
      chk("rst_ready", {28'b0, ch_ready}, 32'd0);

      // single channel, constant x = 100
      reset = 1'b1;
      ch_valid = 4'b0001; samp[0] = 100;
      cycle();
      chk("first_out", out_data, 32'h3200_0000);
      cycle();
`ifdef DC_FAST_SETTLE_EN
      chk("second_out", out_data, 32'd835584000);
`else
      chk("second_out", out_data, 32'd838848000);
`endif
      for (int i = 0; i < 300; i++) cycle();

      // all channels streaming, round-robin order
      reset = 1'b0; idle_inputs(); cycle();
      reset = 1'b1; ch_valid = 4'b1111;
      for (int i = 0; i < 40; i++) begin
         for (int c = 0; c < N; c++) samp[c] = int'($urandom_range(0, 511)) - 256;
         cycle();
         chk("rr_order", {30'b0, out_ch}, i % N);
      end

      // backpressure for three cycles, then release
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) cycle();
      out_ready = 1'b1;
      cycle();
      cycle();

      // clear and valid together on ch1
      reset = 1'b0; idle_inputs(); cycle();
      reset = 1'b1;
      ch_valid = 4'b0001; samp[0] = 3; cycle();
      ch_valid = 4'b0110; ch_clear = 4'b0010; samp[1] = 50; samp[2] = 20; cycle();
      chk("clr_grant", {30'b0, out_ch}, 32'd2);
      ch_valid = 4'b0010; ch_clear = 4'b0000; samp[1] = -5; cycle();
      chk("clr_ch1", out_data, 32'hFD80_0000);

      // reset while an output is pending
      ch_valid = 4'b0001; samp[0] = 9; out_ready = 1'b0; cycle();
      ch_valid = 4'b0000; reset = 1'b0; cycle();
      chk("rst_pending", {31'b0, out_valid}, 32'd0);
      reset = 1'b1; out_ready = 1'b1; ch_valid = 4'b0001; samp[0] = 7; cycle();
      chk("post_rst_ch", {30'b0, out_ch}, 32'd0);
      chk("post_rst_data", out_data, 32'd58720256);

      // randomized traffic
      for (int i = 0; i < 1500; i++) begin
         ch_valid  = N'($urandom_range(0, 15));
         ch_clear  = '0;
         for (int c = 0; c < N; c++) begin
            if ($urandom_range(0, 15) == 0) ch_clear[c] = 1'b1;
            samp[c] = int'($urandom_range(0, 511)) - 256;
         end
         enable    = ($urandom_range(0, 9) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         reset     = ($urandom_range(0, 199) != 0);
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/dc_filter_scheduler.md
# dc_filter_scheduler

Time-multiplexed controller that shares one DC-blocking filter datapath among `N_CH` 9-bit sample streams on the 3 MHz domain. It arbitrates channel requests round-robin, keeps per-channel filter state (previous input, previous output), and computes one filtered sample per cycle. Results go into a single-entry registered output with valid/ready backpressure. It sits between the per-channel decimated sample sources and the downstream exchanger/packer, and replaces per-channel filter instances.

## Interface
- `N_CH`, 4: number of channel requesters (2..8).
- `SHIFT`, 16: steady-state leak shift; pole is 1 − 2^−SHIFT.
- `FAST_SHIFT`, 8: settle-phase shift (used only with `DC_FAST_SETTLE_EN`).
- `SETTLE_SAMPLES`, 256: per-channel sample count in the settle phase.
- `CLK_3M`  in  1: clock, all logic on rising edge.
- `reset`  in  1: synchronous, active-low.
- `enable`  in  1: when low, no new grants; a pending output still drains.
- `ch_valid`  in  N_CH: channel i has a sample.
- `ch_data`  in  9·N_CH: signed samples, channel i at bits [9i+8:9i].
- `ch_clear`  in  N_CH: zero channel i state (and settle counter).
- `ch_ready`  out  N_CH: one-hot grant; transfer when `ch_valid[i] & ch_ready[i]`.
- `out_valid`  out  1: result held.
- `out_ready`  in  1: consumer accepts.
- `out_ch`  out  $clog2(N_CH): channel of held result.
- `out_data`  out  N_DECIMALS+9 (32): signed Q9.23 filtered sample.

## Operation
- Per-channel state: `b[i]` (9-bit signed), `e[i]` (32-bit signed); both reset to 0.
- Slot free = `!out_valid | out_ready`. Grant allowed when `reset` high, `enable` high, slot free.
- Round-robin: search starts at `last+1` mod N_CH, first i with `ch_valid[i] & !ch_clear[i]` is granted. `last` updates on each transfer. Reset value N_CH−1, so channel 0 has first priority.
- `ch_ready` is combinational from `ch_valid`. Sources must not make `ch_valid` depend on `ch_ready`.
- Datapath for granted channel k with sample x, all signed, 32-bit:
  - c = x − b[k]
  - es = e[k] >>> s, rounding bit r = e[k][s−1]
  - g = e[k] − (es + r)
  - d = (c <<< 23) + g
  - s = SHIFT, or FAST_SHIFT in settle phase.
  - No saturation; two's-complement wrap in 32 bits.
- On transfer: b[k] ← x; e[k] ← d; out_data ← d; out_ch ← k; out_valid ← 1.
- `out_valid` clears on `out_ready` when no new transfer occurs that cycle.
- `ch_clear[i]`: b[i], e[i] and settle count go to 0 next cycle. Clear beats grant, so channel i is not granted that cycle. Any held output for i is unaffected.
- Non-transferred channels keep their state.

## Timing
- Reset values: `out_valid` 0, `out_data` 0, `out_ch` 0, `ch_ready` 0 while `reset` low, all state 0, `last` = N_CH−1.
- Latency: sample transferred at edge n appears on `out_data` after edge n (one cycle).
- Throughput: one sample per cycle with `out_ready` held high.
- Backpressure: `out_valid & !out_ready` keeps `out_data`/`out_ch` stable and `ch_ready` all-zero.
- `enable` low mid-stream: no grants. The held output completes normally.
- Reset low mid-operation: next edge returns everything to reset values. A pending output is discarded.

## Configuration
- `DC_FAST_SETTLE_EN` defined:
  - Each channel has a counter of transferred samples, saturating at SETTLE_SAMPLES, cleared by reset/`ch_clear`.
  - s = FAST_SHIFT while count < SETTLE_SAMPLES, else SHIFT.
- Undefined: no counters, s = SHIFT always.

## Structure
- `dc_filter_pkg` holds:
  - `N_DECIMALS` = 23, `SAMPLE_W` = 9, `OUT_W` = 32.
  - typedefs `sample_t` (logic signed [8:0]) and `acc_t` (logic signed [31:0]).
- Sub-module `rr_arbiter` (parameter N): inputs req, en, advance; outputs one-hot grant and index. Holds `last`.
- Filter arithmetic stays inline in `dc_filter_scheduler`.

## Test plan
- Ch0 only, x=100 constant, SHIFT=16, macro off:
  - out 0x3200_0000 (838860800), then 838848000.
  - e decays toward 0 monotonically.
- Macro on, same stimulus: second output 835584000 (shift 8). After 256 samples the step uses shift 16.
- All 4 valid continuously, `out_ready`=1: `out_ch` sequence 0,1,2,3,0,…, one result per cycle, per-channel values matching independent single-channel runs.
- `out_ready` low 3 cycles with all valid: `out_data`/`out_ch` frozen, `ch_ready`=0. On release, the next grant goes to the next channel in round-robin order.
- `ch_clear[1]` and `ch_valid[1]` in the same cycle: ch1 not granted, ch2 granted. The next ch1 sample x=−5 outputs −5·2^23 = 0xFD80_0000.
- `reset` low for one cycle while `out_valid`=1: `out_valid`=0. The first post-reset grant is channel 0, with output equal to x<<23.
